ru_ctrl: RTL and testbench
==========================

RU_CTRL -- requirements
Module: ru_ctrl

Interface
REQ-001 SHALL have parameter Bf, default 8, fractional bits of the fixed-point format.
REQ-002 SHALL have parameter FIX_POINT_WIDTH, default 16, datapath word width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_mode  in  2  operation select, 0..3.
- req_a, req_b  in  FIX_POINT_WIDTH  request operands.
- ru_mode  out  2  mode to the reduction unit.
- ru_valid  out  1  round flag to the reduction unit: 0 = first round of a 2-round op, else 1.
- ru_s_mux  out  1  reduction-unit mux select.
- ru_s_mult  out  3  reduction-unit constant-multiplier select.
- ru_in0, ru_in1  out  FIX_POINT_WIDTH  reduction-unit operands.
- ru_out0, ru_out1, ru_u  in  FIX_POINT_WIDTH  combinational reduction-unit results.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_out0, rsp_out1, rsp_u  out  FIX_POINT_WIDTH  registered final-step results.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed-operation counter.

Function
REQ-005 SHALL implement FSM IDLE -> STEP0 -> (STEP1) -> DONE -> IDLE.
REQ-006 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, latch req_mode, req_a and req_b, then enter STEP0.
REQ-007 SHALL drive microprogram steps as follows (s_mux, s_mult, valid, in0, in1):
- mode 0, 1 step: (0, 0, 1, a, b).
- mode 1, 2 steps: STEP0 (1, 3, 0, a, b); STEP1 (1, 1, 1, r1, a).
- mode 2, 2 steps: STEP0 (1, 4, 0, a, b); STEP1 (1, 2, 1, r1, a).
- mode 3, 1 step: (1, 5, 1, a, b).
REQ-008 SHALL register ru_out1 into r1 at the end of STEP0; STEP1 SHALL consume r1 the following cycle.
REQ-009 SHALL drive ru_mode with the latched mode in STEP0 and STEP1.
REQ-010 SHALL drive ru_s_mux, ru_s_mult, ru_in0 and ru_in1 to 0 and ru_valid to 1 outside STEP0 and STEP1.
REQ-011 SHALL register ru_out0, ru_out1 and ru_u into the rsp_* registers at the end of the last step, then enter DONE.
REQ-012 SHALL assert rsp_valid exactly in DONE.
REQ-013 SHALL hold rsp_* stable while rsp_valid && !rsp_ready.
REQ-014 SHALL return to IDLE on rsp_ready, leaving rsp_* unchanged until the next capture.
REQ-015 SHALL meet latency, with acceptance at edge T: rsp_valid high from T+2 for 1-step modes and from T+3 for 2-step modes; minimum throughput is one op per 3 cycles for 1-step modes and one per 4 for 2-step modes.
REQ-016 SHALL increment op_count on each rsp_valid&&rsp_ready handshake, wrapping 0xFFFF -> 0x0000.
REQ-017 SHALL not accept a request while busy; req_valid in non-IDLE states is ignored and no input is latched.
REQ-018 SHALL treat all arithmetic as unsigned modulo 2^FIX_POINT_WIDTH; no internal arithmetic beyond the counter.

Reset
REQ-019 SHALL, on rst_n low at a clock edge, including mid-operation, go to IDLE; clear latched operands, r1, rsp_*, op_count and rsp_valid; set req_ready to 1 and busy to 0. Any in-flight op is discarded without a response.
REQ-020 SHALL drive REQ-010 idle values on all ru_* outputs during and immediately after reset.

Structure
REQ-021 SHALL place the state encoding, mode codes 0..3, per-mode step count and per-step (s_mux, s_mult, valid, operand-source) constants in shared package ru_ctrl_pkg.
REQ-022 SHALL place the step table in one sub-module, ru_ctrl_prog: combinational (mode, step) -> control fields.
REQ-023 SHALL NOT instantiate the reduction unit; integration connects it externally.

Verification
REQ-024 SHALL cover mode 0, a=0x0100, b=0x0200, rsp_ready=1: one STEP0 cycle with s_mux=0, s_mult=0, ru_valid=1; rsp_valid at T+2; rsp_* equal the sampled ru outputs; op_count=1.
REQ-025 SHALL cover mode 1, a=0x0180, b=0x0040, with ru_out1 stubbed to 0x0333 in STEP0: STEP0 shows (1, 3, 0); STEP1 shows ru_in0=0x0333, ru_in1=0x0180, s_mult=1, ru_valid=1; rsp_valid at T+3.
REQ-026 SHALL cover backpressure with rsp_ready=0 for 5 cycles: rsp_* and rsp_valid stable, req_ready=0, a second request ignored; rsp_ready=1 -> IDLE next cycle.
REQ-027 SHALL cover reset during STEP1 of mode 2: next cycle IDLE, rsp_valid=0, op_count=0, ru_* at idle values, no response emitted.
REQ-028 SHALL cover counter wrap: op_count preloaded to 0xFFFF by 65535 back-to-back mode-3 ops, then one more handshake -> 0x0000.

Source files
------------

// File: rtl/ru_ctrl_pkg.sv
// ru_ctrl_pkg -- shared definitions for the reduction-unit controller.
// Holds the FSM state encoding, operation mode codes, per-mode step count
// and the microprogram step constants consumed by ru_ctrl_prog.
package ru_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP0 = 2'd1,
    ST_STEP1 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_t;

  // Where each reduction-unit operand comes from during a step.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_R1   = 2'd3
  } src_t;

  typedef struct packed {
    logic       s_mux;
    logic [2:0] s_mult;
    logic       valid;
    src_t       src0;
    src_t       src1;
  } step_ctrl_t;

  // Values driven to the reduction unit whenever no step is active.
  localparam step_ctrl_t STEP_IDLE = '{s_mux: 1'b0, s_mult: 3'd0, valid: 1'b1,
                                       src0: SRC_ZERO, src1: SRC_ZERO};

  localparam step_ctrl_t M0_S0 = '{s_mux: 1'b0, s_mult: 3'd0, valid: 1'b1,
                                   src0: SRC_A, src1: SRC_B};
  localparam step_ctrl_t M1_S0 = '{s_mux: 1'b1, s_mult: 3'd3, valid: 1'b0,
                                   src0: SRC_A, src1: SRC_B};
  localparam step_ctrl_t M1_S1 = '{s_mux: 1'b1, s_mult: 3'd1, valid: 1'b1,
                                   src0: SRC_R1, src1: SRC_A};
  localparam step_ctrl_t M2_S0 = '{s_mux: 1'b1, s_mult: 3'd4, valid: 1'b0,
                                   src0: SRC_A, src1: SRC_B};
  localparam step_ctrl_t M2_S1 = '{s_mux: 1'b1, s_mult: 3'd2, valid: 1'b1,
                                   src0: SRC_R1, src1: SRC_A};
  localparam step_ctrl_t M3_S0 = '{s_mux: 1'b1, s_mult: 3'd5, valid: 1'b1,
                                   src0: SRC_A, src1: SRC_B};

  // Number of reduction-unit steps an operation takes.
  function automatic logic [1:0] step_count(mode_t m);
    case (m)
      MODE_1, MODE_2: step_count = 2'd2;
      default:        step_count = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/ru_ctrl_prog.sv
// ru_ctrl_prog -- combinational microprogram table.
// Ports:
//   mode  : latched operation mode
//   step  : 0 = first step, 1 = second step
//   ctrl  : s_mux / s_mult / valid / operand sources for this step
//   last  : high when this step is the final one of the operation
module ru_ctrl_prog
  import ru_ctrl_pkg::*;
(
  input  mode_t      mode,
  input  logic       step,
  output step_ctrl_t ctrl,
  output logic       last
);

  always_comb begin
    ctrl = STEP_IDLE;
    case (mode)
      MODE_0:  ctrl = M0_S0;
      MODE_1:  ctrl = step ? M1_S1 : M1_S0;
      MODE_2:  ctrl = step ? M2_S1 : M2_S0;
      MODE_3:  ctrl = M3_S0;
      default: ctrl = STEP_IDLE;
    endcase
  end

  assign last = step || (step_count(mode) == 2'd1);

endmodule

// File: rtl/ru_ctrl.sv
// ru_ctrl -- request/response sequencer for an external reduction unit.
// Accepts one request in IDLE, runs one or two microprogram steps that drive
// the reduction unit, captures its combinational results and holds them in
// DONE until the consumer accepts.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   req_valid/req_ready/req_mode/req_a/req_b : request handshake and operands
//   ru_mode/ru_valid/ru_s_mux/ru_s_mult/ru_in0/ru_in1 : reduction-unit controls
//   ru_out0/ru_out1/ru_u           : reduction-unit results (combinational)
//   rsp_valid/rsp_ready/rsp_out0/rsp_out1/rsp_u : response handshake and data
//   busy                           : any state other than IDLE
//   op_count                       : completed-operation counter (wraps)
module ru_ctrl
  import ru_ctrl_pkg::*;
#(
  parameter int Bf              = 8,
  parameter int FIX_POINT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_mode,
  input  logic [FIX_POINT_WIDTH-1:0] req_a,
  input  logic [FIX_POINT_WIDTH-1:0] req_b,
  output logic [1:0]                 ru_mode,
  output logic                       ru_valid,
  output logic                       ru_s_mux,
  output logic [2:0]                 ru_s_mult,
  output logic [FIX_POINT_WIDTH-1:0] ru_in0,
  output logic [FIX_POINT_WIDTH-1:0] ru_in1,
  input  logic [FIX_POINT_WIDTH-1:0] ru_out0,
  input  logic [FIX_POINT_WIDTH-1:0] ru_out1,
  input  logic [FIX_POINT_WIDTH-1:0] ru_u,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [FIX_POINT_WIDTH-1:0] rsp_out0,
  output logic [FIX_POINT_WIDTH-1:0] rsp_out1,
  output logic [FIX_POINT_WIDTH-1:0] rsp_u,
  output logic                       busy,
  output logic [15:0]                op_count
);

  // The controller never interprets the fixed-point format; Bf only has to
  // describe a legal format for the attached reduction unit.
  if (Bf < 0 || Bf > FIX_POINT_WIDTH) begin : g_bf_check
    $error("ru_ctrl: Bf must lie within 0..FIX_POINT_WIDTH");
  end

  state_t                     state_q, state_d;
  mode_t                      mode_q;
  logic [FIX_POINT_WIDTH-1:0] a_q, b_q, r1_q;
  logic [FIX_POINT_WIDTH-1:0] rsp0_q, rsp1_q, rspu_q;
  logic [15:0]                cnt_q;

  step_ctrl_t ctrl;
  logic       last;
  logic       in_step;
  logic       accept;

  assign in_step = (state_q == ST_STEP0) || (state_q == ST_STEP1);
  assign accept  = (state_q == ST_IDLE) && req_valid;

  ru_ctrl_prog u_prog (
    .mode (mode_q),
    .step (state_q == ST_STEP1),
    .ctrl (ctrl),
    .last (last)
  );

  function automatic logic [FIX_POINT_WIDTH-1:0] pick(
    src_t                       src,
    logic [FIX_POINT_WIDTH-1:0] a,
    logic [FIX_POINT_WIDTH-1:0] b,
    logic [FIX_POINT_WIDTH-1:0] r1
  );
    case (src)
      SRC_A:   pick = a;
      SRC_B:   pick = b;
      SRC_R1:  pick = r1;
      default: pick = '0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_STEP0;
      ST_STEP0: state_d = last ? ST_DONE : ST_STEP1;
      ST_STEP1: state_d = ST_DONE;
      ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_DONE);
    ru_mode   = 2'd0;
    ru_s_mux  = STEP_IDLE.s_mux;
    ru_s_mult = STEP_IDLE.s_mult;
    ru_valid  = STEP_IDLE.valid;
    ru_in0    = '0;
    ru_in1    = '0;
    if (in_step) begin
      ru_mode   = mode_q;
      ru_s_mux  = ctrl.s_mux;
      ru_s_mult = ctrl.s_mult;
      ru_valid  = ctrl.valid;
      ru_in0    = pick(ctrl.src0, a_q, b_q, r1_q);
      ru_in1    = pick(ctrl.src1, a_q, b_q, r1_q);
    end
  end

  // Operand, intermediate, response and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_0;
      a_q    <= '0;
      b_q    <= '0;
      r1_q   <= '0;
      rsp0_q <= '0;
      rsp1_q <= '0;
      rspu_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode_t'(req_mode);
        a_q    <= req_a;
        b_q    <= req_b;
      end
      if (in_step && !last) begin
        r1_q <= ru_out1;
      end
      if (in_step && last) begin
        rsp0_q <= ru_out0;
        rsp1_q <= ru_out1;
        rspu_q <= ru_u;
      end
      if (state_q == ST_DONE && rsp_ready) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign rsp_out0 = rsp0_q;
  assign rsp_out1 = rsp1_q;
  assign rsp_u    = rspu_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_ru_ctrl.sv
// tb_ru_ctrl -- randomized bench for ru_ctrl with a transaction-level model.
// The reduction unit is stubbed with deterministic functions of its inputs;
// the model expands each accepted request into its expected step records and
// final response, and a negedge process compares the DUT every cycle.
module tb_ru_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_mode;
  logic [W-1:0]  req_a, req_b;
  logic [1:0]    ru_mode;
  logic          ru_valid, ru_s_mux;
  logic [2:0]    ru_s_mult;
  logic [W-1:0]  ru_in0, ru_in1, ru_out0, ru_out1, ru_u;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_out0, rsp_out1, rsp_u;
  logic          busy;
  logic [15:0]   op_count;

  always #5 clk = ~clk;

  ru_ctrl #(.Bf(8), .FIX_POINT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .ru_mode(ru_mode), .ru_valid(ru_valid), .ru_s_mux(ru_s_mux),
    .ru_s_mult(ru_s_mult), .ru_in0(ru_in0), .ru_in1(ru_in1),
    .ru_out0(ru_out0), .ru_out1(ru_out1), .ru_u(ru_u),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out0(rsp_out0), .rsp_out1(rsp_out1), .rsp_u(rsp_u),
    .busy(busy), .op_count(op_count)
  );

  typedef struct packed {
    logic [1:0]   mode;
    logic         s_mux;
    logic [2:0]   s_mult;
    logic         valid;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
  } step_t;

  // Reduction-unit stub
  function automatic logic [W-1:0] stub0(step_t s);
    return s.in0 + s.in1 + {9'd0, s.mode, s.s_mux, s.s_mult, s.valid};
  endfunction
  function automatic logic [W-1:0] stub1(step_t s, logic ovr);
    if (ovr && !s.valid) return 16'h0333;
    return (s.in0 ^ {s.in1[7:0], s.in1[15:8]}) + {13'd0, s.s_mult};
  endfunction
  function automatic logic [W-1:0] stubu(step_t s);
    return (s.in0 - s.in1) ^ (s.valid ? 16'h5A5A : 16'hA5A5);
  endfunction

  logic  stub_ovr;
  step_t ru_view;
  always_comb begin
    ru_view = '{mode: ru_mode, s_mux: ru_s_mux, s_mult: ru_s_mult,
                valid: ru_valid, in0: ru_in0, in1: ru_in1};
    ru_out0 = stub0(ru_view);
    ru_out1 = stub1(ru_view, stub_ovr);
    ru_u    = stubu(ru_view);
  end

  // Checking infrastructure
  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      if (nfail >= 200) begin
        $display("FAIL abort: too many mismatches");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $fatal(1);
      end
    end
  endtask

  // Behavioural model
  step_t        steps_q[$];
  logic         resp_pend;
  logic [W-1:0] fin0, fin1, finu;
  logic [W-1:0] m_rsp0, m_rsp1, m_rspu;
  logic [15:0]  m_count;
  logic         started;

  function automatic step_t mk(logic [1:0] m, logic sm, logic [2:0] mu, logic v,
                               logic [W-1:0] i0, logic [W-1:0] i1);
    return '{mode: m, s_mux: sm, s_mult: mu, valid: v, in0: i0, in1: i1};
  endfunction

  task automatic build(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    step_t s0, last_s;
    case (m)
      2'd0: steps_q.push_back(mk(2'd0, 1'b0, 3'd0, 1'b1, a, b));
      2'd1: begin
        s0 = mk(2'd1, 1'b1, 3'd3, 1'b0, a, b);
        steps_q.push_back(s0);
        steps_q.push_back(mk(2'd1, 1'b1, 3'd1, 1'b1, stub1(s0, stub_ovr), a));
      end
      2'd2: begin
        s0 = mk(2'd2, 1'b1, 3'd4, 1'b0, a, b);
        steps_q.push_back(s0);
        steps_q.push_back(mk(2'd2, 1'b1, 3'd2, 1'b1, stub1(s0, stub_ovr), a));
      end
      default: steps_q.push_back(mk(2'd3, 1'b1, 3'd5, 1'b1, a, b));
    endcase
    last_s = steps_q[$];
    fin0 = stub0(last_s);
    fin1 = stub1(last_s, stub_ovr);
    finu = stubu(last_s);
    resp_pend = 1'b1;
  endtask

  initial begin
    steps_q.delete();
    resp_pend = 1'b0;
    {fin0, fin1, finu} = '0;
    {m_rsp0, m_rsp1, m_rspu} = '0;
    m_count = '0;
    started = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        steps_q.delete();
        resp_pend = 1'b0;
        {m_rsp0, m_rsp1, m_rspu} = '0;
        m_count = '0;
      end else if (steps_q.size() != 0) begin
        if (steps_q.size() == 1) begin
          m_rsp0 = fin0;
          m_rsp1 = fin1;
          m_rspu = finu;
        end
        void'(steps_q.pop_front());
      end else if (resp_pend) begin
        if (rsp_ready) begin
          resp_pend = 1'b0;
          m_count   = m_count + 16'd1;
        end
      end else if (req_valid) begin
        build(req_mode, req_a, req_b);
      end
      started = 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    step_t       e;
    logic [2:0]  st;
    if (started) begin
      if (steps_q.size() != 0) begin
        e  = steps_q[0];
        st = 3'b010;
      end else begin
        e  = mk(2'd0, 1'b0, 3'd0, 1'b1, '0, '0);
        st = resp_pend ? 3'b011 : 3'b100;
      end
      chk("ru_ctrl_fields",
          {25'd0, ru_mode, ru_s_mux, ru_s_mult, ru_valid, ru_in0, ru_in1},
          {25'd0, e.mode, e.s_mux, e.s_mult, e.valid, e.in0, e.in1});
      chk("status", {45'd0, req_ready, busy, rsp_valid, op_count},
          {45'd0, st, m_count});
      chk("rsp_data", {16'd0, rsp_out0, rsp_out1, rsp_u},
          {16'd0, m_rsp0, m_rsp1, m_rspu});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; stub_ovr = 1'b0;
    req_mode = 2'd0; req_a = '0; req_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    neg();
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_ru_idle", {ru_s_mux, ru_s_mult, ru_valid, ru_in0, ru_in1}, {5'b00001, 32'd0});

    // Mode 0, single step
    tick();
    req_valid = 1'b1; req_mode = 2'd0; req_a = 16'h0100; req_b = 16'h0200;
    neg();
    chk("m0_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    neg();
    chk("m0_step0_ctrl", {ru_s_mux, ru_s_mult, ru_valid}, 5'b0_000_1);
    chk("m0_step0_in", {ru_in0, ru_in1}, 32'h0100_0200);
    chk("m0_no_early_rsp", rsp_valid, 0);
    tick();
    neg();
    chk("m0_rsp_valid_t2", rsp_valid, 1);
    chk("m0_rsp_data", {rsp_out0, rsp_out1, rsp_u}, 48'h0301_0102_A55A);
    tick();
    neg();
    chk("m0_op_count", op_count, 1);
    chk("m0_back_idle", {busy, req_ready}, 2'b01);

    // Mode 1, two steps with r1 forced to 0x0333
    tick();
    stub_ovr = 1'b1;
    req_valid = 1'b1; req_mode = 2'd1; req_a = 16'h0180; req_b = 16'h0040;
    tick();
    req_valid = 1'b0;
    neg();
    chk("m1_step0_ctrl", {ru_mode, ru_s_mux, ru_s_mult, ru_valid}, 7'b01_1_011_0);
    tick();
    neg();
    chk("m1_step1_in", {ru_in0, ru_in1}, 32'h0333_0180);
    chk("m1_step1_ctrl", {ru_s_mult, ru_valid}, 4'b001_1);
    chk("m1_no_rsp_t2", rsp_valid, 0);
    tick();
    neg();
    chk("m1_rsp_valid_t3", rsp_valid, 1);
    chk("m1_rsp_out0", rsp_out0, 16'h04E6);
    tick();
    stub_ovr = 1'b0;

    // Backpressure with a competing request
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_mode = 2'd3; req_a = 16'h1234; req_b = 16'h00FF;
    tick();
    req_a = 16'hBEEF; req_b = 16'hCAFE; req_mode = 2'd0;
    tick();
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_hold", {rsp_out0, rsp_out1, rsp_u}, {m_rsp0, m_rsp1, m_rspu});
      tick();
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    tick();
    neg();
    chk("bp_release_idle", {busy, req_ready, rsp_valid}, 3'b010);
    chk("bp_op_count", op_count, 3);

    // Reset during STEP1 of mode 2
    tick();
    req_valid = 1'b1; req_mode = 2'd2; req_a = 16'h4321; req_b = 16'h0F0F;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    neg();
    chk("rst_in_step1", {ru_s_mult, ru_valid}, 4'b010_1);
    tick();
    rst_n = 1'b1;
    neg();
    chk("rst_mid_state", {busy, req_ready, rsp_valid}, 3'b010);
    chk("rst_mid_count", op_count, 0);
    chk("rst_mid_ru_idle", {ru_mode, ru_s_mux, ru_s_mult, ru_valid, ru_in0, ru_in1},
        {7'b00_0_000_1, 32'd0});
    chk("rst_mid_rsp_clear", {rsp_out0, rsp_out1, rsp_u}, 48'd0);
    repeat (3) tick();
    neg();
    chk("rst_no_response", rsp_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick();
      req_valid = 1'($urandom_range(0, 1));
      req_mode  = 2'($urandom_range(0, 3));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst_n     = ($urandom_range(0, 99) != 0);
    end

    // Counter wrap using back-to-back mode-3 operations
    tick();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    req_valid = 1'b1; req_mode = 2'd3; req_a = 16'h0A0A; req_b = 16'h5050;
    for (int i = 0; i < 200000 && m_count != 16'hFFFF; i++) tick();
    neg();
    chk("wrap_preload", op_count, 16'hFFFF);
    for (int i = 0; i < 10 && m_count != 16'h0000; i++) tick();
    neg();
    chk("wrap_to_zero", op_count, 16'h0000);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
